// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream packet checker.
package axis_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RX      = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   localparam logic [1:0] BP_ALWAYS = 2'd0;
   localparam logic [1:0] BP_ALT    = 2'd1;
   localparam logic [1:0] BP_LFSR   = 2'd2;
   localparam logic [1:0] BP_NEVER  = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shift form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {^(cur & LFSR_TAPS), cur[15:1]};
   endfunction

endpackage

// File: rtl/axis_thr_meter.sv
// Counts accepted beats over fixed windows of WIN_CYC clocks and publishes
// the total of each completed window with a one-cycle valid pulse.
module axis_thr_meter #(
   parameter int WIN_CYC = 10000,
   parameter int THR_W   = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             beat_acc,
   output logic [THR_W-1:0] thr_cnt,
   output logic             thr_valid
);

   localparam int CYC_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

   logic [CYC_W-1:0] cyc_cnt;
   logic [THR_W-1:0] beat_cnt;
   logic [THR_W-1:0] beat_sum;
   logic             terminal;

   assign terminal = (cyc_cnt == CYC_W'(WIN_CYC - 1));
   // The terminal cycle's own beat belongs to the window being closed.
   assign beat_sum = beat_cnt + THR_W'(beat_acc);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc_cnt   <= '0;
         beat_cnt  <= '0;
         thr_cnt   <= '0;
         thr_valid <= 1'b0;
      end else begin
         thr_valid <= terminal;
         if (terminal) begin
            cyc_cnt  <= '0;
            beat_cnt <= '0;
            thr_cnt  <= beat_sum;
         end else begin
            cyc_cnt  <= cyc_cnt + CYC_W'(1);
            beat_cnt <= beat_sum;
         end
      end
   end

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI-Stream sink: drives tready with a selectable backpressure pattern,
// checks packet length and tkeep, counts packets and measures throughput.
module axis_pkt_checker
   import axis_chk_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int KEEP_W    = 8,
   parameter int EXP_BEATS = 512,
   parameter int WIN_CYC   = 10000,
   parameter int THR_W     = 14,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        bp_mode,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tlast,
   input  logic [KEEP_W-1:0] s_axis_tkeep,
   output logic [CNT_W-1:0]  o_pkt_cnt,
   output logic [CNT_W-1:0]  o_err_cnt,
   output logic              o_len_err,
   output logic              o_keep_err,
   output logic [THR_W-1:0]  o_thr_cnt,
   output logic              o_thr_valid,
   output logic              o_busy
);

   localparam int BCNT_W = $clog2(EXP_BEATS + 1);
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(EXP_BEATS);

   state_t            state;
   logic [BCNT_W-1:0] beat_cnt;
   logic [BCNT_W-1:0] beat_num;
   logic              bad;
   logic              alt_tgl;
   logic [15:0]       lfsr;
   logic              pattern;
   logic              beat_acc;
   logic              chk_beat;
   logic              keep_hit;
   logic              short_hit;
   logic              long_hit;
   logic              pkt_done;
   logic              done_bad;
   logic              unused_data;

   assign unused_data = ^s_axis_tdata;

   always_comb begin
      pattern = 1'b0;
      case (bp_mode)
         BP_ALWAYS: pattern = 1'b1;
         BP_ALT:    pattern = alt_tgl;
         BP_LFSR:   pattern = lfsr[0];
         BP_NEVER:  pattern = 1'b0;
      endcase
   end

   // Handshake: a beat transfers on a rising edge where tvalid && tready.
   // tready never looks at tvalid; it is held low throughout reset.
   assign s_axis_tready = rst & en & pattern;
   assign beat_acc      = s_axis_tvalid & s_axis_tready;

   // Number of the beat being accepted now (1-based within the packet).
   assign beat_num  = (state == ST_IDLE) ? BCNT_W'(1) : beat_cnt + BCNT_W'(1);
   assign chk_beat  = beat_acc && (state != ST_DISCARD);
   assign keep_hit  = chk_beat && (s_axis_tkeep != '1);
   assign short_hit = chk_beat && s_axis_tlast && (beat_num != LAST_BEAT);
   assign long_hit  = chk_beat && !s_axis_tlast && (beat_num == LAST_BEAT);
   assign pkt_done  = beat_acc && s_axis_tlast;
   assign done_bad  = (state == ST_DISCARD) || bad || keep_hit || short_hit;
   assign o_busy    = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         beat_cnt   <= '0;
         bad        <= 1'b0;
         alt_tgl    <= 1'b1;
         lfsr       <= LFSR_SEED;
         o_pkt_cnt  <= '0;
         o_err_cnt  <= '0;
         o_len_err  <= 1'b0;
         o_keep_err <= 1'b0;
      end else begin
         alt_tgl    <= ~alt_tgl;
         lfsr       <= lfsr_next(lfsr);
         o_keep_err <= keep_hit;
         o_len_err  <= short_hit | long_hit;

         if (pkt_done) begin
            if (done_bad) begin
               if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_W'(1);
            end else begin
               if (o_pkt_cnt != '1) o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
            end
         end

         if (beat_acc) begin
            case (state)
               ST_IDLE, ST_RX: begin
                  if (s_axis_tlast) begin
                     state    <= ST_IDLE;
                     beat_cnt <= '0;
                     bad      <= 1'b0;
                  end else if (long_hit) begin
                     // Overlong packet: already counted as a length error,
                     // the rest is swallowed up to its tlast.
                     state    <= ST_DISCARD;
                     beat_cnt <= '0;
                     bad      <= 1'b0;
                  end else begin
                     state    <= ST_RX;
                     beat_cnt <= beat_num;
                     bad      <= bad | keep_hit;
                  end
               end
               ST_DISCARD: begin
                  if (s_axis_tlast) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   axis_thr_meter #(
      .WIN_CYC (WIN_CYC),
      .THR_W   (THR_W)
   ) u_thr_meter (
      .clk       (clk),
      .rst       (rst),
      .beat_acc  (beat_acc),
      .thr_cnt   (o_thr_cnt),
      .thr_valid (o_thr_valid)
   );

endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
Downstream sink for the 64-bit AXI-Stream test-packet generator on the 10G datapath. It drives tready with a selectable backpressure pattern and checks packet length and tkeep. It counts good and bad packets and reports accepted-beat throughput per fixed window. It is used in loopback and bring-up to exercise the generator's tready handling and to measure link-side throughput.

Parameters:
DATA_W, 64, tdata width
KEEP_W, 8, tkeep width (DATA_W/8)
EXP_BEATS, 512, required beats per packet; tlast on beat EXP_BEATS
WIN_CYC, 10000, throughput window length in clk cycles
THR_W, 14, throughput counter width; must hold WIN_CYC
CNT_W, 32, packet/error counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
en  in  1  checker enable; 0 forces tready low
bp_mode  in  2  tready pattern: 0 always, 1 alternate, 2 LFSR random, 3 never
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tdata  in  DATA_W  stream data (not checked)
s_axis_tlast  in  1  end of packet
s_axis_tkeep  in  KEEP_W  byte enables; all ones required on every beat
o_pkt_cnt  out  CNT_W  good packets received, saturating
o_err_cnt  out  CNT_W  bad packets received, saturating
o_len_err  out  1  one-cycle pulse on a length error
o_keep_err  out  1  one-cycle pulse on a tkeep error
o_thr_cnt  out  THR_W  accepted beats in the last complete window
o_thr_valid  out  1  one-cycle pulse when o_thr_cnt updates
o_busy  out  1  high while state != IDLE

Behaviour:
- Reset: clk and rst are as already decided (reset rst, synchronous, active-low; clock clk). While rst=0, all outputs are 0, including s_axis_tready. State goes to IDLE, the beat counter and bad flag clear, the alternate toggle is set to 1, and the LFSR loads 16'hACE1.
- Reset applied mid-packet abandons the packet without counting it.
- Handshake: a beat is accepted when tvalid && tready.
- tready = en && pattern. It never depends on tvalid and is driven only from registers, bp_mode and en.
- Pattern for each mode:
  - mode 0: 1.
  - mode 1: a toggle flop that inverts every cycle, giving 1,0,1,...
  - mode 2: lfsr[0]. The LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances every cycle after reset.
  - mode 3: 0.
- en=0 freezes the FSM and beat counter. The window meter keeps running.
- FSM states:
  - IDLE: the first accepted beat goes to RX with beat_cnt=1; if that beat has tlast, it is checked as a complete packet immediately.
  - RX: each accepted beat increments beat_cnt. Beat counter width is clog2(EXP_BEATS+1).
  - DISCARD: accepted beats are ignored until a beat with tlast, then go to IDLE.
- Length rules, for the accepted beat numbered n:
  - tlast at n == EXP_BEATS: packet ends; go to IDLE.
  - tlast at n < EXP_BEATS: short error; go to IDLE.
  - n == EXP_BEATS without tlast: long error; go to DISCARD.
  - Exactly one length error is raised per packet.
- Keep rule: any accepted beat in IDLE or RX with tkeep != all-ones pulses o_keep_err and sets the packet's bad flag.
- End of packet (the tlast in IDLE/RX, or the DISCARD exit): o_pkt_cnt increments if the packet was good, otherwise o_err_cnt increments. Each counter saturates at all-ones.
- Error pulses and counter updates are registered: they appear 1 cycle after the offending or terminating handshake.
- Keep and length error on the same beat: both pulses fire, and the packet is counted as one error.
- Throughput window:
  - A cycle counter runs 0..WIN_CYC-1 and wraps.
  - Accepted beats are counted on every cycle, including the terminal one.
  - On the terminal cycle, o_thr_cnt is loaded with the count including that cycle's beat, o_thr_valid pulses for 1 cycle, and the beat counter restarts at 0.
  - The first pulse occurs on the WIN_CYC-th cycle after reset release.

Decomposition:
- Package axis_chk_pkg: FSM state enum (IDLE, RX, DISCARD), bp_mode encodings, LFSR seed and tap constants.
- Sub-module axis_thr_meter (params WIN_CYC, THR_W; inputs beat_acc; outputs thr_cnt, thr_valid) holds the window logic and is reusable by the generator side.

Test Plan:
- mode 0, en=1, one 512-beat packet, tkeep=FF, tlast on beat 512 -> o_pkt_cnt=1, o_err_cnt=0, no error pulses, o_busy low after the packet.
- Packet with tlast on beat 100 -> o_len_err pulses once, o_err_cnt=1. A following 512-beat packet -> o_pkt_cnt=1.
- 520-beat packet with tlast on beat 520 -> o_len_err pulses 1 cycle after beat 512. Beats 513..520 are discarded, o_err_cnt=1. The next good packet is counted.
- Beat 3 with tkeep=0x0F in a 512-beat packet -> o_keep_err pulses once, o_err_cnt=1, o_pkt_cnt unchanged.
- tvalid held high. mode 0 -> first o_thr_cnt=10000. mode 1 -> 5000. mode 3 -> 0, with o_thr_valid every 10000 cycles.
- rst low at beat 200 of a packet -> all outputs 0 and tready 0 during reset. After release, a full packet -> o_pkt_cnt=1, o_err_cnt=0.
